// File: rtl/des_pkg.sv
// Shared DES definitions: block/byte widths, packer state encoding and the
// byte-to-lane bit reversal used by the ingress packer and egress unpacker.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAD  = 2'd2
  } pack_state_e;

  // DES numbers bits MSB-first, so a byte's MSB lands on the lowest bit of its lane.
  function automatic logic [DES_BYTE_W-1:0] des_byte_lane(input logic [DES_BYTE_W-1:0] b);
    logic [DES_BYTE_W-1:0] r;
    for (int i = 0; i < DES_BYTE_W; i++) begin
      r[i] = b[DES_BYTE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_block_packer.sv
// Byte-serial ingress packer: assembles bytes into 64-bit DES-ordered blocks,
// applies PKCS#5 padding (or zero fill) on the final block of a message, and
// buffers one completed block while the output register is occupied.
module des_block_packer
  import des_pkg::*;
#(
  parameter bit PAD_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DES_BYTE_W-1:0]  s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DES_BLOCK_W-1:0] m_block,
  output logic                   m_last
);

  localparam logic [DES_BYTE_W-1:0]  PAD_BYTE  = 8'h08;
  localparam logic [DES_BLOCK_W-1:0] PAD_BLOCK = {8{des_byte_lane(PAD_BYTE)}};

  pack_state_e              state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [DES_BLOCK_W-1:0]   asm_q, asm_d;
  logic                     hold_last_q, hold_last_d;
  logic                     hold_pad_q, hold_pad_d;
  logic                     en_q, en_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_last_q, m_last_d;
  logic [DES_BLOCK_W-1:0]   m_block_q, m_block_d;

  logic                     s_fire;
  logic                     out_free;
  logic                     aligned;
  logic                     complete;
  logic                     comp_last;
  logic                     comp_pad;
  logic [DES_BYTE_W-1:0]    fill_byte;
  logic [DES_BLOCK_W-1:0]   comp_block;

  // Ready is registered state only, never a function of s_valid/s_last.
  assign s_ready  = en_q && (state_q == FILL);
  assign s_fire   = s_valid && s_ready;
  assign out_free = !m_valid_q || m_ready;
  assign en_d     = 1'b1;

  assign m_valid  = m_valid_q;
  assign m_block  = m_block_q;
  assign m_last   = m_last_q;

  // Merge the incoming byte into the assembly image and fill the lanes above it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fill_byte  = PAD_EN ? (8'd7 - {5'd0, cnt_q}) : 8'h00;
    aligned    = (cnt_q == 3'd7);
    complete   = aligned || s_last;
    comp_pad   = PAD_EN && aligned && s_last;
    comp_last  = s_last && !comp_pad;
    comp_block = asm_q;
    for (int i = 0; i < 8; i++) begin
      if (i == int'(cnt_q)) begin
        comp_block[8*i +: 8] = des_byte_lane(s_data);
      end else if (i > int'(cnt_q)) begin
        comp_block[8*i +: 8] = des_byte_lane(fill_byte);
      end
    end
  end

  // Next-state and output-register load decisions for FILL/HOLD/PAD.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    hold_last_d = hold_last_q;
    hold_pad_d  = hold_pad_q;
    m_valid_d   = m_valid_q && !m_ready;
    m_block_d   = m_block_q;
    m_last_d    = m_last_q;
    unique case (state_q)
      FILL: begin
        if (s_fire) begin
          asm_d = comp_block;
          cnt_d = cnt_q + 3'd1;
          if (complete) begin
            cnt_d = 3'd0;
            if (out_free) begin
              m_valid_d = 1'b1;
              m_block_d = comp_block;
              m_last_d  = comp_last;
              state_d   = comp_pad ? PAD : FILL;
            end else begin
              hold_last_d = comp_last;
              hold_pad_d  = comp_pad;
              state_d     = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_block_d = asm_q;
          m_last_d  = hold_last_q;
          state_d   = hold_pad_q ? PAD : FILL;
        end
      end
      PAD: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_block_d = PAD_BLOCK;
          m_last_d  = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, assembly and output registers; reset drops all partial and held data.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the assembly register is reset too, so a block built after reset can never
    // carry bytes left over from an abandoned message.
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= 3'd0;
      asm_q       <= '0;
      hold_last_q <= 1'b0;
      hold_pad_q  <= 1'b0;
      en_q        <= 1'b0;
      m_valid_q   <= 1'b0;
      m_block_q   <= '0;
      m_last_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      hold_last_q <= hold_last_d;
      hold_pad_q  <= hold_pad_d;
      en_q        <= en_d;
      m_valid_q   <= m_valid_d;
      m_block_q   <= m_block_d;
      m_last_q    <= m_last_d;
    end
  end

endmodule
